// File: rtl/resize_scheduler.sv
// resize_scheduler
//   Accepts a raster of WIDTH x HEIGHT source pixels, decimates it by 1, 2 or
//   4 in both directions and emits the surviving pixels as sequential writes
//   into an output buffer.
//
// Ports
//   horizontal_clock   single clock, rising edge
//   horizontal_reset   asynchronous reset, active low
//   start              frame request, only looked at in IDLE
//   scale_sel[1:0]     0 = 1:1, 1 = 1/2, 2 = 1/4, 3 behaves as 2
//   src_sync           source pixel valid
//   src_r/g/b[7:0]     source pixel data
//   src_start          one-cycle kick to the source (ARM state)
//   busy               high in every state except IDLE
//   wr_en              output buffer write strobe (registered)
//   wr_addr[16:0]      output buffer address, holds between writes
//   wr_data[23:0]      {r,g,b} of the kept pixel, 0 when wr_en is low
//   frame_done         one-cycle end-of-frame pulse (DONE state)
//   error              sticky source-timeout flag
//   dbg_state[1:0]     current FSM state, for observation only
//
// Source handshake: src_sync is a valid-only strobe. There is no ready; in
// STREAM every cycle with src_sync=1 consumes exactly one pixel, in any other
// state the strobe and data are ignored.
module resize_scheduler #(
  parameter int WIDTH   = 384,
  parameter int HEIGHT  = 256,
  parameter int TIMEOUT = 1023
) (
  input  logic        horizontal_clock,
  input  logic        horizontal_reset,
  input  logic        start,
  input  logic [1:0]  scale_sel,
  input  logic        src_sync,
  input  logic [7:0]  src_r,
  input  logic [7:0]  src_g,
  input  logic [7:0]  src_b,
  output logic        src_start,
  output logic        busy,
  output logic        wr_en,
  output logic [16:0] wr_addr,
  output logic [23:0] wr_data,
  output logic        frame_done,
  output logic        error,
  output logic [1:0]  dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state, state_next;

  logic [1:0]    scale;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [TW-1:0] idle_cnt;
  logic [16:0]   keep_cnt;

  logic launch, accept, stall, expire, keep;
  logic [1:0] mask;

  assign dbg_state = state;

  // Low bits of the position that must be zero for a pixel to survive.
  assign mask = (scale == 2'd2) ? 2'b11 : (scale == 2'd1) ? 2'b01 : 2'b00;
  assign keep = accept && ((2'(col) & mask) == 2'b00) && ((2'(row) & mask) == 2'b00);

  always_ff @(posedge horizontal_clock or negedge horizontal_reset) begin
    if (!horizontal_reset) state <= IDLE;
    else                   state <= state_next;
  end

  always_comb begin
    state_next = state;
    src_start  = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    launch     = 1'b0;
    accept     = 1'b0;
    stall      = 1'b0;
    expire     = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          launch     = 1'b1;
          state_next = ARM;
        end
      end
      ARM: begin
        src_start  = 1'b1;
        state_next = STREAM;
      end
      STREAM: begin
        if (src_sync) begin
          accept = 1'b1;
          if (col == COL_LAST && row == ROW_LAST) state_next = DONE;
        end else begin
          stall = 1'b1;
          // This idle cycle is the TIMEOUT-th in a row: give up on the frame.
          if (idle_cnt == IDLE_LAST) begin
            expire     = 1'b1;
            state_next = IDLE;
          end
        end
      end
      DONE: begin
        frame_done = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge horizontal_clock or negedge horizontal_reset) begin
    if (!horizontal_reset) begin
      scale    <= 2'd0;
      col      <= '0;
      row      <= '0;
      idle_cnt <= '0;
      keep_cnt <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      error    <= 1'b0;
    end else begin
      wr_en   <= keep;
      wr_data <= keep ? {src_r, src_g, src_b} : 24'd0;

      if (launch) begin
        scale    <= (scale_sel == 2'd3) ? 2'd2 : scale_sel;
        col      <= '0;
        row      <= '0;
        idle_cnt <= '0;
        keep_cnt <= '0;
        wr_addr  <= '0;
        error    <= 1'b0;
      end

      if (accept) begin
        idle_cnt <= '0;
        if (col == COL_LAST) begin
          col <= '0;
          row <= row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end

      // wr_addr is the number of pixels kept before this one.
      if (keep) begin
        wr_addr  <= keep_cnt;
        keep_cnt <= keep_cnt + 17'd1;
      end

      if (stall && !expire) idle_cnt <= idle_cnt + TW'(1);
      if (expire)           error    <= 1'b1;
    end
  end

endmodule
